// File: rtl/inst_rom_pkg.sv
// Shared constants and types for the instruction ROM with byte-stream loader.
package inst_rom_pkg;

  localparam int unsigned InstW               = 32;
  localparam int unsigned InstAddrW           = 32;
  localparam logic [31:0] ZeroWord            = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [31:0] NopInst             = 32'h0000_0013;
  localparam int unsigned RomDepthLog2Default = 10;

  typedef enum logic {
    StLoad,
    StRun
  } ld_state_e;

endpackage

// File: rtl/inst_rom_mem.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
module inst_rom_mem
  import inst_rom_pkg::*;
#(
  parameter int unsigned AddrW = RomDepthLog2Default
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [InstW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [InstW-1:0] rdata_o
);

  logic [InstW-1:0] mem_q [0:(1<<AddrW)-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A same-cycle write is not visible until the next cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom.sv
// Instruction ROM filled from a little-endian byte stream; holds the CPU while loading.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int unsigned ROM_DEPTH_LOG2 = RomDepthLog2Default
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rom_ce,
  input  logic [InstAddrW-1:0]    rom_addr,
  output logic [InstW-1:0]        rom_inst,
  input  logic                    ld_valid,
  input  logic [7:0]              ld_data,
  input  logic                    ld_last,
  output logic                    ld_ready,
  input  logic                    ld_start,
  output logic                    cpu_hold,
  output logic                    load_done,
  output logic                    load_err,
  output logic [ROM_DEPTH_LOG2:0] load_words
);

  localparam int unsigned AW      = ROM_DEPTH_LOG2;
  localparam logic [AW:0] FullPtr = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PtrOne  = (AW + 1)'(1);

  ld_state_e         state_q;
  logic [1:0]        byte_cnt_q;
  logic [AW:0]       word_ptr_q;
  logic [AW:0]       load_words_q;
  logic              load_err_q;
  logic [InstW-1:0]  shreg_q;

  logic              full;
  logic              word_end;
  logic              mem_we;
  logic [InstW-1:0]  word_asm;
  logic [InstW-1:0]  mem_rdata;

  assign full     = (word_ptr_q == FullPtr);
  assign word_end = (byte_cnt_q == 2'd3) || ld_last;

  // Bytes not yet received stay zero, which zero-pads a short final word.
  always_comb begin
    word_asm = shreg_q;
    word_asm[{byte_cnt_q, 3'b000} +: 8] = ld_data;
  end

  assign mem_we = ~rst && (state_q == StLoad) && ld_valid && ~full && word_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      byte_cnt_q   <= 2'd0;
      word_ptr_q   <= '0;
      load_words_q <= '0;
      load_err_q   <= 1'b0;
      shreg_q      <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (ld_valid) begin
            if (full) begin
              load_err_q <= 1'b1;
            end else if (word_end) begin
              word_ptr_q   <= word_ptr_q + PtrOne;
              load_words_q <= load_words_q + PtrOne;
              byte_cnt_q   <= 2'd0;
              shreg_q      <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              shreg_q    <= word_asm;
            end
            if (ld_last) begin
              state_q    <= StRun;
              byte_cnt_q <= 2'd0;
              word_ptr_q <= '0;
              shreg_q    <= '0;
            end
          end
        end
        StRun: begin
          if (ld_start) begin
            state_q      <= StLoad;
            byte_cnt_q   <= 2'd0;
            word_ptr_q   <= '0;
            load_words_q <= '0;
            load_err_q   <= 1'b0;
            shreg_q      <= '0;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  inst_rom_mem #(
    .AddrW(AW)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(word_ptr_q[AW-1:0]),
    .wdata_i(word_asm),
    .raddr_i(rom_addr[AW+1:2]),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    if (!rom_ce) begin
      rom_inst = ZeroWord;
    end else if (rom_addr[InstAddrW-1:AW+2] == '0) begin
      rom_inst = mem_rdata;
    end else begin
      rom_inst = NopInst;
    end
  end

  assign ld_ready   = (state_q == StLoad);
  assign cpu_hold   = (state_q == StLoad);
  assign load_done  = (state_q == StRun);
  assign load_err   = load_err_q;
  assign load_words = load_words_q;

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: default-depth instance plus a 4-word instance for overflow.
module tb_inst_rom;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rom_ce, ld_valid, ld_last, ld_start;
  logic [31:0] rom_addr, rom_inst;
  logic [7:0]  ld_data;
  logic        ld_ready, cpu_hold, load_done, load_err;
  logic [10:0] load_words;

  logic        s_rst, s_rom_ce, s_ld_valid, s_ld_last, s_ld_start;
  logic [31:0] s_rom_addr, s_rom_inst;
  logic [7:0]  s_ld_data;
  logic        s_ld_ready, s_cpu_hold, s_load_done, s_load_err;
  logic [2:0]  s_load_words;

  int errors = 0;
  int checks = 0;

  inst_rom u_dut (
    .clk       (clk),
    .rst       (rst),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_start  (ld_start),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .load_words(load_words)
  );

  inst_rom #(
    .ROM_DEPTH_LOG2(2)
  ) u_dut_small (
    .clk       (clk),
    .rst       (s_rst),
    .rom_ce    (s_rom_ce),
    .rom_addr  (s_rom_addr),
    .rom_inst  (s_rom_inst),
    .ld_valid  (s_ld_valid),
    .ld_data   (s_ld_data),
    .ld_last   (s_ld_last),
    .ld_ready  (s_ld_ready),
    .ld_start  (s_ld_start),
    .cpu_hold  (s_cpu_hold),
    .load_done (s_load_done),
    .load_err  (s_load_err),
    .load_words(s_load_words)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    rom_ce   = 1'b1;
    rom_addr = addr;
    #1;
    check(tag, rom_inst, exp);
  endtask

  task automatic fetch_small(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    s_rom_ce   = 1'b1;
    s_rom_addr = addr;
    #1;
    check(tag, s_rom_inst, exp);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic send_small(input logic [7:0] d, input logic last);
    @(negedge clk);
    s_ld_valid = 1'b1;
    s_ld_data  = d;
    s_ld_last  = last;
    @(posedge clk);
    #1;
    s_ld_valid = 1'b0;
    s_ld_last  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    ld_start = 1'b1;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rom_ce = 1'b0; rom_addr = '0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; ld_start = 1'b0;
    s_rst = 1'b1; s_rom_ce = 1'b0; s_rom_addr = '0; s_ld_valid = 1'b0; s_ld_data = '0;
    s_ld_last = 1'b0; s_ld_start = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_load_words", 32'(load_words), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First image: two words, last flag on the 8th byte.
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    fetch("load_read_w0", 32'h0, 32'h0000_0013);
    check("load_words_mid", 32'(load_words), 32'd1);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 8'h00; ld_last = 1'b1;
    #1;
    check("hold_before_last", 32'(cpu_hold), 32'd1);
    @(posedge clk);
    #1;
    ld_valid = 1'b0; ld_last = 1'b0;
    check("hold_after_last", 32'(cpu_hold), 32'd0);
    check("done_after_last", 32'(load_done), 32'd1);
    check("ready_in_run", 32'(ld_ready), 32'd0);
    check("words_img1", 32'(load_words), 32'd2);

    fetch("run_addr4", 32'h4, 32'h0010_0093);
    fetch("run_addr6", 32'h6, 32'h0010_0093);
    fetch("run_addr0", 32'h0, 32'h0000_0013);
    fetch("oor_alias", 32'h0000_1004, 32'h0000_0013);
    rom_ce = 1'b0;
    #1;
    check("ce_low", rom_inst, 32'h0);

    // Bytes offered in RUN are not taken.
    send_byte(8'hFF, 1'b1);
    check("run_ignore_words", 32'(load_words), 32'd2);
    check("run_ignore_done", 32'(load_done), 32'd1);
    fetch("run_ignore_w0", 32'h0, 32'h0000_0013);

    // ld_start with a byte in the same cycle: byte dropped, counters cleared.
    @(negedge clk);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h55;
    @(posedge clk);
    #1;
    ld_start = 1'b0; ld_valid = 1'b0;
    check("restart_ready", 32'(ld_ready), 32'd1);
    check("restart_words", 32'(load_words), 32'd0);
    check("restart_err", 32'(load_err), 32'd0);
    fetch("restart_keep_w1", 32'h4, 32'h0010_0093);

    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    pulse_start();
    check("start_in_load_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'hCC, 1'b0);
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 8'hDD; ld_last = 1'b0;
    fetch("same_cycle_old", 32'h0, 32'h0000_0013);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    fetch("load_read_new", 32'h0, 32'hDDCC_BBAA);
    send_byte(8'hEE, 1'b1);
    check("words_img2", 32'(load_words), 32'd2);
    check("done_img2", 32'(load_done), 32'd1);
    fetch("img2_w0", 32'h0, 32'hDDCC_BBAA);
    fetch("img2_w1_pad", 32'h4, 32'h0000_00EE);

    // Reset mid-load, with a last byte offered in the reset cycle.
    pulse_start();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    @(negedge clk);
    rst = 1'b1; ld_valid = 1'b1; ld_data = 8'h77; ld_last = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_hold", 32'(cpu_hold), 32'd1);
    check("midrst_words", 32'(load_words), 32'd0);
    @(negedge clk);
    rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    check("img3_words", 32'(load_words), 32'd1);
    check("img3_done", 32'(load_done), 32'd1);
    fetch("img3_w0", 32'h0, 32'h4433_2211);
    fetch("img3_w1_kept", 32'h4, 32'h0000_00EE);

    // Four-word ROM overflowed by a 20-byte image.
    @(negedge clk);
    s_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_small(8'(i + 1), (i == 19));
      if (i == 15) begin
        check("small_full_err0", 32'(s_load_err), 32'd0);
        check("small_full_words", 32'(s_load_words), 32'd4);
      end
      if (i == 18) begin
        check("small_drain_err", 32'(s_load_err), 32'd1);
        check("small_drain_ready", 32'(s_ld_ready), 32'd1);
      end
    end
    check("small_done", 32'(s_load_done), 32'd1);
    check("small_words", 32'(s_load_words), 32'd4);
    check("small_err_sticky", 32'(s_load_err), 32'd1);
    fetch_small("small_w0", 32'h0, 32'h0403_0201);
    fetch_small("small_w3", 32'hC, 32'h100F_0E0D);
    fetch_small("small_oor", 32'h10, 32'h0000_0013);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 Parameter: ROM_DEPTH_LOG2, default 10, log2 of word capacity (1024 x 32-bit).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rom_ce  input  1  fetch enable from CPU.
REQ-005 rom_addr  input  32  byte fetch address from CPU.
REQ-006 rom_inst  output  32  fetched instruction word.
REQ-007 ld_valid  input  1  loader byte valid.
REQ-008 ld_data  input  8  loader byte.
REQ-009 ld_last  input  1  marks final byte of image; qualified by ld_valid.
REQ-010 ld_ready  output  1  loader byte accepted when ld_valid & ld_ready.
REQ-011 ld_start  input  1  pulse; re-enters load mode from RUN.
REQ-012 cpu_hold  output  1  high while loading; holds CPU in reset.
REQ-013 load_done  output  1  high in RUN.
REQ-014 load_err  output  1  sticky overflow flag for current load.
REQ-015 load_words  output  ROM_DEPTH_LOG2+1  count of words written in current load.

Function
REQ-016 Fetch read is combinational, zero-cycle latency: rom_inst valid in the same cycle as rom_addr.
REQ-017 rom_ce=0 -> rom_inst = 32'h0.
REQ-018 rom_ce=1, rom_addr[31:ROM_DEPTH_LOG2+2]==0 -> rom_inst = mem[rom_addr[ROM_DEPTH_LOG2+1:2]]; rom_addr[1:0] ignored.
REQ-019 rom_ce=1 with an out-of-range address -> rom_inst = 32'h00000013 (NOP).
REQ-020 FSM states: LOAD, RUN. LOAD: ld_ready=1, cpu_hold=1, load_done=0. RUN: ld_ready=0, cpu_hold=0, load_done=1.
REQ-021 Byte assembly is little-endian: the k-th accepted byte of a word (k=0..3) goes to bits [8k+7:8k].
REQ-022 On acceptance of the 4th byte, the assembled word is written to mem[word_ptr] in that cycle; word_ptr and load_words increment; byte_cnt returns to 0.
REQ-023 On acceptance of a byte with ld_last=1: the current word, zero-padded in its unfilled upper bytes, is written (if its index is in range); FSM -> RUN next cycle; byte_cnt, word_ptr reset to 0.
REQ-024 Full: a byte accepted with word_ptr == 2^ROM_DEPTH_LOG2 is discarded, load_err set; ld_ready stays 1 (drain) until the ld_last byte, then RUN.
REQ-025 ld_start in RUN -> LOAD next cycle; byte_cnt, word_ptr, load_words, load_err cleared; memory contents retained. ld_start in LOAD is ignored.
REQ-026 ld_valid without ld_ready (RUN) is ignored; no state change.
REQ-027 Fetch reads during LOAD return current array contents (including words written in earlier cycles).
REQ-028 A write and a fetch to the same word in the same cycle return the old contents.

Reset
REQ-029 rst -> state LOAD, byte_cnt=0, word_ptr=0, load_words=0, load_err=0, byte shift register=0; outputs ld_ready=1, cpu_hold=1, load_done=0.
REQ-030 rst mid-load abandons the partial word; no write occurs in the reset cycle; memory array is not cleared.
REQ-031 rst has priority over ld_start and loader handshakes in the same cycle.

Structure
REQ-032 Shared defines header holds `InstBus, `InstAddrBus, `ZeroWord, the NOP encoding constant, and the ROM_DEPTH_LOG2 default.
REQ-033 One sub-module inst_rom_mem: 2^ROM_DEPTH_LOG2 x 32 array, one synchronous write port, one asynchronous read port; FSM and byte assembler live in inst_rom.

Verification
REQ-034 Reset, stream 8 bytes 13 00 00 00 93 00 10 00 (last on 8th) -> mem[0]=0x00000013, mem[1]=0x00100093, load_words=2, cpu_hold falls one cycle after the last byte is accepted.
REQ-035 RUN, rom_ce=1, rom_addr=0x4 -> rom_inst=0x00100093 in the same cycle; rom_addr=0x6 -> same; rom_ce=0 -> 0x0.
REQ-036 Stream 5 bytes AA BB CC DD EE (last on EE) -> mem[0]=0xDDCCBBAA, mem[1]=0x000000EE, load_words=2.
REQ-037 ROM_DEPTH_LOG2=2: stream 20 bytes -> words 0..3 written, load_err=1, load_words=4, ld_ready stays high until last byte; rom_addr=0x10 -> 0x00000013.
REQ-038 Assert rst after 6 bytes, then load 4 bytes 11 22 33 44 -> mem[0]=0x44332211, word_ptr restarted at 0, no write during reset cycle.
REQ-039 In RUN pulse ld_start with ld_valid=1 -> byte not accepted that cycle; LOAD entered next cycle with load_words=0, load_err=0, prior contents still readable.
